// File: rtl/data_memory.sv
// Per-thread banked data memory with one-cycle registered read, write-first bypass,
// and a sequencer that zero-fills the whole array after reset or a clear request.
module data_memory #(
    parameter int  DATA_WIDTH         = 64,
    parameter int  THREAD_INDEX_BITS  = 3,
    parameter int  DATA_MEM_ADDR_BITS = 8,
    localparam int ADDR_BITS          = THREAD_INDEX_BITS + DATA_MEM_ADDR_BITS,
    localparam int DEPTH              = 2 ** ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BITS-1:0]  in_raddr,
    input  logic [ADDR_BITS-1:0]  in_waddr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  in_we,
    input  logic                  in_clear,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_ready
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  clr_cnt_q, clr_cnt_d;

    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  user_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_raw_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic                  byp_q;
    logic                  rd_valid_q;

    // A write in the same cycle as a clear is dropped.
    assign user_we = in_we && !in_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = in_waddr;
        mem_wdata = in_wdata;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                mem_we    = user_we;
                clr_cnt_d = '0;
                if (in_clear) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Storage and raw read port kept reset-free so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_raw_q   <= mem[in_raddr];
        byp_data_q <= in_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            byp_q      <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == ST_READY);
            byp_q      <= (state_q == ST_READY) && user_we && (in_raddr == in_waddr);
        end
    end

    assign out_rdata = !rd_valid_q ? '0 : (byp_q ? byp_data_q : rd_raw_q);
    assign out_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected results tagged with the
// cycle they are due, and a negedge monitor compares them against the DUT outputs.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] in_raddr = '0;
    logic [10:0] in_waddr = '0;
    logic [63:0] in_wdata = '0;
    logic        in_we = 1'b0;
    logic        in_clear = 1'b0;
    logic [63:0] out_rdata;
    logic        out_ready;

    data_memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_raddr  (in_raddr),
        .in_waddr  (in_waddr),
        .in_wdata  (in_wdata),
        .in_we     (in_we),
        .in_clear  (in_clear),
        .out_rdata (out_rdata),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_ready;
        logic [63:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every item due this cycle, flag any that were missed.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [63:0] got;
                got = q[i].is_ready ? {63'd0, out_ready} : out_rdata;
                total_cnt++;
                if (q[i].due < cyc) begin
                    $display("FAIL %s: check missed (due cycle %0d, now %0d)", q[i].name, q[i].due, cyc);
                end else if (got !== q[i].exp) begin
                    $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, got, q[i].exp, cyc);
                end else begin
                    pass_cnt++;
                end
                q.delete(i);
            end
        end
    end

    task automatic push(input int due, input bit is_ready, input logic [63:0] exp, input string nm);
        item_t it;
        it.due = due;
        it.is_ready = is_ready;
        it.exp = exp;
        it.name = nm;
        q.push_back(it);
    endtask

    // One cycle of stimulus; optionally expect read data in the following cycle.
    task automatic op(input logic we, input logic [10:0] wa, input logic [63:0] wd,
                      input logic [10:0] ra, input logic clr,
                      input bit chk, input logic [63:0] exp, input string nm);
        in_we = we;
        in_waddr = wa;
        in_wdata = wd;
        in_raddr = ra;
        in_clear = clr;
        if (chk) push(cyc + 1, 1'b0, exp, nm);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(1'b0, 11'h0, 64'h0, 11'h0, 1'b0, 1'b0, 64'h0, "");
    endtask

    initial begin
        int c0;
        int c1;
        int cc;

        // 1. reset and full INIT
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 2048; i++) begin
            push(c0 + i, 1'b1, (i == 2048) ? 64'd1 : 64'd0, "init_ready");
            push(c0 + i, 1'b0, 64'd0, "init_rdata");
        end
        idle(2048);

        // 3. read-during-write bypass and independent addresses
        op(1'b1, 11'h020, 64'h1234, 11'h020, 1'b0, 1'b1, 64'h1234, "bypass_same");
        op(1'b1, 11'h020, 64'h1234, 11'h021, 1'b0, 1'b1, 64'h0, "bypass_other");
        op(1'b0, 11'h000, 64'h0, 11'h020, 1'b0, 1'b1, 64'h1234, "readback_20");

        // 4. thread isolation
        op(1'b1, {3'd1, 8'd5}, 64'hAA, 11'h0, 1'b0, 1'b0, 64'h0, "");
        op(1'b1, {3'd2, 8'd5}, 64'hBB, 11'h0, 1'b0, 1'b0, 64'h0, "");
        op(1'b0, 11'h0, 64'h0, {3'd1, 8'd5}, 1'b0, 1'b1, 64'hAA, "thread1_w5");
        op(1'b0, 11'h0, 64'h0, {3'd2, 8'd5}, 1'b0, 1'b1, 64'hBB, "thread2_w5");
        op(1'b0, 11'h0, 64'h0, {3'd0, 8'd5}, 1'b0, 1'b1, 64'h0, "thread0_w5");

        // 2. write then read 0x105
        op(1'b1, 11'h105, 64'hDEADBEEF_CAFEF00D, 11'h0, 1'b0, 1'b0, 64'h0, "");
        op(1'b0, 11'h0, 64'h0, 11'h105, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D, "read_105");

        // 5. clear together with a write to 0x7FF
        cc = cyc;
        push(cc + 1, 1'b1, 64'd0, "clear_ready_fall");
        push(cc + 2, 1'b0, 64'd0, "clear_rdata_init");
        push(cc + 2048, 1'b1, 64'd0, "clear_ready_last");
        push(cc + 2049, 1'b1, 64'd1, "clear_ready_rise");
        op(1'b1, 11'h7FF, 64'h1, 11'h105, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, "clear_cycle_read");
        idle(2048);
        op(1'b0, 11'h0, 64'h0, 11'h105, 1'b0, 1'b1, 64'h0, "cleared_105");
        op(1'b0, 11'h0, 64'h0, 11'h7FF, 1'b0, 1'b1, 64'h0, "cleared_7ff");

        // 6. reset in the middle of INIT
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1000);
        rst_n = 1'b0;
        push(cyc + 1, 1'b1, 64'd0, "midinit_rst_ready");
        push(cyc + 1, 1'b0, 64'd0, "midinit_rst_rdata");
        @(negedge clk);
        rst_n = 1'b1;
        c1 = cyc;
        push(c1 + 2047, 1'b1, 64'd0, "reinit_ready_last");
        push(c1 + 2048, 1'b1, 64'd1, "reinit_ready_rise");
        op(1'b1, 11'h010, 64'h55, 11'h010, 1'b0, 1'b1, 64'h0, "init_write_bypass");
        idle(2047);
        op(1'b0, 11'h0, 64'h0, 11'h010, 1'b0, 1'b1, 64'h0, "init_write_dropped");
        op(1'b1, 11'h010, 64'h77, 11'h0, 1'b0, 1'b0, 64'h0, "");
        op(1'b0, 11'h0, 64'h0, 11'h010, 1'b0, 1'b1, 64'h77, "ready_write_10");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total_cnt++;
            $display("FAIL leftover_checks: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
